dcache_arbiter: RTL and testbench

DCACHE_ARBITER -- requirements
Module: dcache_arbiter

---
 rtl/dcache_arbiter.sv | 150 +++++++++++++++
 tb/tb_dcache_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_arbiter.sv
// Data-cache request arbiter.
// Merges two requesters (port 0: load/store queue, port 1: secondary) onto a single
// cache request channel with round-robin priority, limits outstanding reads to MAX_OUT,
// and routes read responses back to the issuing port by ldstID_in[3].
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/rw/addr/wdata/id  requester N issue; reqN_ready is the combinational grant
//   addr_out/data_out/rw_out/valid_out/ldstID_out  registered cache request ({port, id})
//   data_in/ldstID_in/ready_in   cache read response
//   stall_in                  cache cannot take a request this cycle
//   respN_valid/data/id       registered response to requester N
//   out_cnt                   outstanding-read count
//   err_out                   sticky: response arrived with nothing outstanding
module dcache_arbiter #(
   parameter int unsigned MAX_OUT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic        req1_valid,
   input  logic        req0_rw,
   input  logic        req1_rw,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req0_wdata,
   input  logic [31:0] req1_wdata,
   input  logic [2:0]  req0_id,
   input  logic [2:0]  req1_id,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic [31:0] addr_out,
   output logic [31:0] data_out,
   output logic        rw_out,
   output logic        valid_out,
   output logic [3:0]  ldstID_out,
   input  logic [31:0] data_in,
   input  logic [3:0]  ldstID_in,
   input  logic        ready_in,
   input  logic        stall_in,
   output logic        resp0_valid,
   output logic        resp1_valid,
   output logic [31:0] resp0_data,
   output logic [31:0] resp1_data,
   output logic [2:0]  resp0_id,
   output logic [2:0]  resp1_id,
   output logic [3:0]  out_cnt,
   output logic        err_out
);

   localparam logic [3:0] MaxOut = 4'(MAX_OUT);

   logic       prio_q, prio_d;
   logic [3:0] out_cnt_q, out_cnt_d;
   logic       err_q, err_d;

   logic       cnt_full;
   logic       elig0, elig1;
   logic       grant0, grant1;
   logic       accept;
   logic       sel_rw;
   logic       resp_ok;
   logic       inc, dec;

   // A read is ineligible at the limit; writes only respect stall.
   always_comb begin
      cnt_full = (out_cnt_q == MaxOut);
      elig0    = req0_valid & ~rst & ~stall_in & (req0_rw | ~cnt_full);
      elig1    = req1_valid & ~rst & ~stall_in & (req1_rw | ~cnt_full);
      grant0   = elig0 & (~elig1 | ~prio_q);
      grant1   = elig1 & (~elig0 | prio_q);
      accept   = grant0 | grant1;
      sel_rw   = grant1 ? req1_rw : req0_rw;
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Responses with nothing outstanding are dropped and flagged.
   always_comb begin
      resp_ok   = ready_in & (out_cnt_q != 4'd0);
      inc       = accept & ~sel_rw;
      dec       = resp_ok;
      out_cnt_d = out_cnt_q;
      if (inc && !dec) begin
         out_cnt_d = out_cnt_q + 4'd1;
      end else if (dec && !inc) begin
         out_cnt_d = out_cnt_q - 4'd1;
      end
      err_d  = err_q | (ready_in & (out_cnt_q == 4'd0));
      prio_d = accept ? ~grant1 : prio_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q    <= 1'b0;
         out_cnt_q <= 4'd0;
         err_q     <= 1'b0;
      end else begin
         prio_q    <= prio_d;
         out_cnt_q <= out_cnt_d;
         err_q     <= err_d;
      end
   end

   assign out_cnt = out_cnt_q;
   assign err_out = err_q;

   // Cache request register: fields hold between accepts, valid pulses once.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out  <= 1'b0;
         addr_out   <= 32'd0;
         data_out   <= 32'd0;
         rw_out     <= 1'b0;
         ldstID_out <= 4'd0;
      end else begin
         valid_out <= accept;
         if (accept) begin
            addr_out   <= grant1 ? req1_addr : req0_addr;
            data_out   <= grant1 ? req1_wdata : req0_wdata;
            rw_out     <= sel_rw;
            ldstID_out <= grant1 ? {1'b1, req1_id} : {1'b0, req0_id};
         end
      end
   end

   // Response register: only the addressed port's data/id are updated.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp0_valid <= 1'b0;
         resp1_valid <= 1'b0;
         resp0_data  <= 32'd0;
         resp1_data  <= 32'd0;
         resp0_id    <= 3'd0;
         resp1_id    <= 3'd0;
      end else begin
         resp0_valid <= resp_ok & ~ldstID_in[3];
         resp1_valid <= resp_ok & ldstID_in[3];
         if (resp_ok && !ldstID_in[3]) begin
            resp0_data <= data_in;
            resp0_id   <= ldstID_in[2:0];
         end
         if (resp_ok && ldstID_in[3]) begin
            resp1_data <= data_in;
            resp1_id   <= ldstID_in[2:0];
         end
      end
   end

endmodule

// File: tb/tb_dcache_arbiter.sv
module tb_dcache_arbiter;

   localparam int unsigned MAX_OUT = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;
      logic [3:0]  id;
   } cache_t;

   typedef struct packed {
      logic        port;
      logic [31:0] data;
      logic [2:0]  id;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_rw, req1_rw;
   logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
   logic [2:0]  req0_id, req1_id;
   logic        req0_ready, req1_ready;
   logic [31:0] addr_out, data_out;
   logic        rw_out, valid_out;
   logic [3:0]  ldstID_out;
   logic [31:0] data_in;
   logic [3:0]  ldstID_in;
   logic        ready_in, stall_in;
   logic        resp0_valid, resp1_valid;
   logic [31:0] resp0_data, resp1_data;
   logic [2:0]  resp0_id, resp1_id;
   logic [3:0]  out_cnt;
   logic        err_out;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model state
   logic       m_prio;
   logic [3:0] m_cnt;
   logic       m_err;
   cache_t     h_cache;
   resp_t      h_r0, h_r1;
   cache_t     cache_q[$];
   resp_t      resp_q[$];

   always #5 clk = ~clk;

   dcache_arbiter #(.MAX_OUT(MAX_OUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_rw    (req0_rw),
      .req1_rw    (req1_rw),
      .req0_addr  (req0_addr),
      .req1_addr  (req1_addr),
      .req0_wdata (req0_wdata),
      .req1_wdata (req1_wdata),
      .req0_id    (req0_id),
      .req1_id    (req1_id),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .addr_out   (addr_out),
      .data_out   (data_out),
      .rw_out     (rw_out),
      .valid_out  (valid_out),
      .ldstID_out (ldstID_out),
      .data_in    (data_in),
      .ldstID_in  (ldstID_in),
      .ready_in   (ready_in),
      .stall_in   (stall_in),
      .resp0_valid(resp0_valid),
      .resp1_valid(resp1_valid),
      .resp0_data (resp0_data),
      .resp1_data (resp1_data),
      .resp0_id   (resp0_id),
      .resp1_id   (resp1_id),
      .out_cnt    (out_cnt),
      .err_out    (err_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      rst        = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_rw    = 1'b0; req1_rw    = 1'b0;
      ready_in   = 1'b0; stall_in   = 1'b0;
   endtask

   task automatic set_req(input int p, input logic v, input logic rw, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] id);
      if (p == 0) begin
         req0_valid = v; req0_rw = rw; req0_addr = a; req0_wdata = d; req0_id = id;
      end else begin
         req1_valid = v; req1_rw = rw; req1_addr = a; req1_wdata = d; req1_id = id;
      end
   endtask

   task automatic set_resp(input logic [3:0] id, input logic [31:0] d);
      ready_in = 1'b1; ldstID_in = id; data_in = d;
   endtask

   // One clock: check grants, update model, then compare registered outputs.
   task automatic step();
      logic ok0, ok1, full, g_any, g_port, inc, dec;
      cache_t c;
      resp_t  r;
      #1;
      full   = (m_cnt == 4'(MAX_OUT));
      ok0    = req0_valid && !rst && !stall_in && (req0_rw || !full);
      ok1    = req1_valid && !rst && !stall_in && (req1_rw || !full);
      g_any  = ok0 || ok1;
      g_port = (ok0 && ok1) ? m_prio : ok1;
      check("req0_ready", 32'(req0_ready), 32'(g_any && !g_port));
      check("req1_ready", 32'(req1_ready), 32'(g_any && g_port));
      if (rst) begin
         cache_q.delete();
         resp_q.delete();
         m_prio  = 1'b0;
         m_cnt   = 4'd0;
         m_err   = 1'b0;
         h_cache = '0;
         h_r0    = '0;
         h_r1    = '0;
      end else begin
         inc = g_any && !(g_port ? req1_rw : req0_rw);
         dec = ready_in && (m_cnt != 4'd0);
         if (g_any) begin
            c.addr = g_port ? req1_addr : req0_addr;
            c.data = g_port ? req1_wdata : req0_wdata;
            c.rw   = g_port ? req1_rw : req0_rw;
            c.id   = {g_port, g_port ? req1_id : req0_id};
            cache_q.push_back(c);
            m_prio = !g_port;
         end
         if (ready_in && m_cnt == 4'd0) m_err = 1'b1;
         if (dec) begin
            r.port = ldstID_in[3];
            r.data = data_in;
            r.id   = ldstID_in[2:0];
            resp_q.push_back(r);
         end
         m_cnt = m_cnt + 4'(inc) - 4'(dec);
      end
      @(posedge clk);
      #1;
      if (cache_q.size() != 0) begin
         h_cache = cache_q.pop_front();
         check("valid_out", 32'(valid_out), 32'd1);
      end else begin
         check("valid_out", 32'(valid_out), 32'd0);
      end
      check("addr_out", addr_out, h_cache.addr);
      check("data_out", data_out, h_cache.data);
      check("rw_out", 32'(rw_out), 32'(h_cache.rw));
      check("ldstID_out", 32'(ldstID_out), 32'(h_cache.id));
      if (resp_q.size() != 0) begin
         r = resp_q.pop_front();
         if (r.port) h_r1 = r;
         else        h_r0 = r;
         check("resp0_valid", 32'(resp0_valid), 32'(!r.port));
         check("resp1_valid", 32'(resp1_valid), 32'(r.port));
      end else begin
         check("resp0_valid", 32'(resp0_valid), 32'd0);
         check("resp1_valid", 32'(resp1_valid), 32'd0);
      end
      check("resp0_data", resp0_data, h_r0.data);
      check("resp0_id", 32'(resp0_id), 32'(h_r0.id));
      check("resp1_data", resp1_data, h_r1.data);
      check("resp1_id", 32'(resp1_id), 32'(h_r1.id));
      check("out_cnt", 32'(out_cnt), 32'(m_cnt));
      check("err_out", 32'(err_out), 32'(m_err));
      @(negedge clk);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      set_req(0, 1'b1, 1'b0, 32'h11, 32'h0, 3'd2);  // valid during reset must not be granted
      set_req(1, 1'b1, 1'b1, 32'h22, 32'h5, 3'd3);
      step();
      step();
      idle();
   endtask

   initial begin
      m_prio = 1'b0; m_cnt = 4'd0; m_err = 1'b0;
      h_cache = '0; h_r0 = '0; h_r1 = '0;
      idle();
      req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
      req0_id = '0; req1_id = '0; data_in = '0; ldstID_in = '0;
      @(negedge clk);
      do_reset();

      // Single read and its response
      set_req(0, 1'b1, 1'b0, 32'd40, 32'd0, 3'd1);
      step();
      idle();
      step();
      set_resp(4'h1, 32'd9000);
      step();
      idle();
      step();

      // Contention from reset, then outstanding limit
      do_reset();
      set_req(0, 1'b1, 1'b0, 32'h100, 32'd0, 3'd4);
      set_req(1, 1'b1, 1'b0, 32'h200, 32'd0, 3'd5);
      repeat (5) step();                            // 4 alternating grants, then blocked
      set_req(1, 1'b1, 1'b1, 32'h300, 32'hABCD, 3'd6);
      step();                                       // write granted at the limit
      set_req(1, 1'b0, 1'b0, 32'h0, 32'd0, 3'd0);
      set_resp(4'h4, 32'h77);
      step();                                       // read still blocked this cycle
      ready_in = 1'b0;
      step();                                       // read granted now
      req0_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_resp(4'(i[0] ? 4'hD : 4'h5), 32'(1000 + i));
         step();
      end
      idle();
      step();

      // Stall with both ports valid
      set_req(0, 1'b1, 1'b1, 32'h400, 32'h1, 3'd1);
      set_req(1, 1'b1, 1'b1, 32'h500, 32'h2, 3'd2);
      stall_in = 1'b1;
      repeat (3) step();
      stall_in = 1'b0;
      repeat (2) step();
      idle();

      // Simultaneous accept and response at out_cnt = 2
      set_req(0, 1'b1, 1'b0, 32'h600, 32'd0, 3'd3);
      repeat (2) step();
      set_resp(4'h3, 32'h1234);
      step();
      idle();
      step();

      // Drain, stray response sets error; reset mid-burst clears it
      set_resp(4'h3, 32'h1);
      repeat (2) step();
      set_resp(4'h0, 32'hDEAD);
      step();
      idle();
      set_req(1, 1'b1, 1'b0, 32'h700, 32'd0, 3'd7);
      repeat (2) step();
      do_reset();
      set_resp(4'hF, 32'hBEEF);
      step();
      idle();
      step();

      // Random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst      = ($urandom_range(0, 59) == 0);
         stall_in = ($urandom_range(0, 4) == 0);
         set_req(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom(),
                 $urandom(), 3'($urandom_range(0, 7)));
         set_req(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), $urandom(),
                 $urandom(), 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 2) == 0) set_resp(4'($urandom_range(0, 15)), $urandom());
         else ready_in = 1'b0;
         step();
      end
      idle();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
